// File: rtl/inv_pkg.sv
// Shared inventory types: default widths, the item record passed between
// the update core, scanner and display, and the scanner FSM encoding.
package inv_pkg;

  localparam int INV_AW = 8;
  localparam int INV_DW = 8;

  typedef struct packed {
    logic [INV_AW-1:0] code;
    logic [INV_DW-1:0] quant;
  } item_rec_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_EMIT   = 3'd4,
    S_FINISH = 3'd5
  } scan_state_t;

endpackage

// File: rtl/scan_rd_delay.sv
// Tracks an issued read strobe through the memory pipeline; o_vld is high
// in the cycle the read data is valid, RD_LAT cycles after i_vld.
module scan_rd_delay #(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vld,
  output logic o_vld
);

  logic [RD_LAT-1:0] r_sh;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh <= '0;
    end else begin
      r_sh[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        r_sh[i] <= r_sh[i-1];
      end
    end
  end

  assign o_vld = r_sh[RD_LAT-1];

endmodule

// File: rtl/stock_scanner.sv
// Sweeps item memory 0..DEPTH-1 after a start pulse and streams every item whose
// quantity is <= the sampled threshold; RD_LAT+2 cycles per item, +1 per emitted item.
module stock_scanner
  import inv_pkg::*;
#(
  parameter int AW     = INV_AW,
  parameter int DW     = INV_DW,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_threshold,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic          o_item_valid,
  input  logic          i_item_ready,
  output logic [AW-1:0] o_item_code,
  output logic [DW-1:0] o_item_quant,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW:0]   o_low_count
);

  // Termination is an equality compare so DEPTH == 2**AW never relies on wrap.
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  scan_state_t   r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_thr;
  logic [DW-1:0] r_quant;
  logic          w_cap;

  scan_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_vld (o_rd_en),
    .o_vld (w_cap)
  );

  assign o_rd_addr = r_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_thr        <= '0;
      r_quant      <= '0;
      o_rd_en      <= 1'b0;
      o_item_valid <= 1'b0;
      o_item_code  <= '0;
      o_item_quant <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_low_count  <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_thr       <= i_threshold;
            r_addr      <= '0;
            o_low_count <= '0;
            o_busy      <= 1'b1;
            o_rd_en     <= 1'b1;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          o_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_cap) begin
            r_quant <= i_rd_data;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_quant <= r_thr) begin
            o_item_valid <= 1'b1;
            o_item_code  <= r_addr;
            o_item_quant <= r_quant;
            r_state      <= S_EMIT;
          end else if (r_addr == LAST) begin
            o_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_addr  <= r_addr + 1'b1;
            o_rd_en <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_EMIT: begin
          // Item fields stay untouched until the consumer takes them.
          if (i_item_ready) begin
            o_item_valid <= 1'b0;
            o_low_count  <= o_low_count + 1'b1;
            if (r_addr == LAST) begin
              o_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_addr  <= r_addr + 1'b1;
              o_rd_en <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_FINISH: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stock_scanner.sv
// Directed bench for stock_scanner: a queue model of the expected items plus
// a per-cycle compare process, pinned by hand-computed literal expectations.
module tb_stock_scanner;

  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] threshold;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          item_valid;
  logic          item_ready;
  logic [AW-1:0] item_code;
  logic [DW-1:0] item_quant;
  logic          busy;
  logic          done;
  logic [AW:0]   low_count;

  always #5 clk = ~clk;

  stock_scanner #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_threshold  (threshold),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_item_valid (item_valid),
    .i_item_ready (item_ready),
    .o_item_code  (item_code),
    .o_item_quant (item_quant),
    .o_busy       (busy),
    .o_done       (done),
    .o_low_count  (low_count)
  );

  // Memory with RD_LAT-cycle read pipeline
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[rd_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[RD_LAT-1];

  typedef struct {
    int code;
    int quant;
  } item_t;

  item_t exp_q[$];
  int    emit_log[$];
  int    exp_rd;
  bit    in_scan;
  int    valid_cycles;
  int    last_lat;
  int    n_vec = 0;
  int    n_err = 0;

  logic          pv, pr;
  logic [AW-1:0] pc;
  logic [DW-1:0] pq;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst && in_scan) begin
      if (rd_en) begin
        check("rd_addr_seq", int'(rd_addr), exp_rd);
        exp_rd++;
      end
      if (pv && !pr) begin
        check("hold_valid", int'(item_valid), 1);
        check("hold_code", int'(item_code), int'(pc));
        check("hold_quant", int'(item_quant), int'(pq));
      end
      if (item_valid) valid_cycles++;
      if (item_valid && item_ready) begin
        check("item_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("item_code", int'(item_code), exp_q[0].code);
          check("item_quant", int'(item_quant), exp_q[0].quant);
          void'(exp_q.pop_front());
        end
        emit_log.push_back(int'(item_code));
      end
      pv = item_valid;
      pr = item_ready;
      pc = item_code;
      pq = item_quant;
    end
  end

  // Runs one scan from just after a posedge. stall: cycles to hold ready low
  // while valid; mid_addr: read address at which to inject start+threshold;
  // abort_code: emitted code at which to assert reset.
  task automatic run_scan(input int thr, input int stall, input int mid_addr,
                          input int abort_code);
    int  exp_cnt;
    int  lat;
    int  st;
    bit  fin;
    bit  aborted;
    exp_q.delete();
    emit_log.delete();
    for (int i = 0; i < DEPTH; i++)
      if (int'(mem[i]) <= thr) exp_q.push_back('{i, int'(mem[i])});
    exp_cnt      = exp_q.size();
    exp_rd       = 0;
    valid_cycles = 0;
    pv           = 1'b0;
    pr           = 1'b1;
    st           = stall;
    fin          = 1'b0;
    aborted      = 1'b0;
    threshold    = DW'(thr);
    start        = 1'b1;
    in_scan      = 1'b1;
    lat          = 1;
    @(posedge clk); #1;
    start     = 1'b0;
    threshold = DW'(thr) ^ 8'hA5;
    while (!fin && !aborted && lat < 5000) begin
      lat++;
      if (done) begin
        fin = 1'b1;
      end else if (abort_code >= 0 && item_valid && int'(item_code) == abort_code) begin
        in_scan = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_item_valid", int'(item_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_low_count", int'(low_count), 0);
        check("rst_item_code", int'(item_code), 0);
        aborted = 1'b1;
      end else begin
        item_ready = !(item_valid && st > 0);
        if (item_valid && st > 0) st--;
        if (mid_addr >= 0 && rd_en && int'(rd_addr) == mid_addr) begin
          start     = 1'b1;
          threshold = 8'd200;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    start      = 1'b0;
    item_ready = 1'b1;
    last_lat   = lat;
    if (aborted) begin
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check("no_done_after_rst", int'(done | busy), 0);
      end
    end else begin
      check("done_seen", int'(fin), 1);
      check("low_count_model", int'(low_count), exp_cnt);
      check("all_items_out", exp_q.size(), 0);
      check("busy_at_done", int'(busy), 1);
      @(posedge clk); #1;
      in_scan = 1'b0;
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    threshold  = '0;
    item_ready = 1'b1;
    in_scan    = 1'b0;
    pv = 1'b0; pr = 1'b1; pc = '0; pq = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd10;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_valid", int'(item_valid), 0);
    check("reset_count", int'(low_count), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: nothing qualifies
    run_scan(5, 0, -1, -1);
    check("t1_latency", last_lat, 256 * (RD_LAT + 2) + 2);
    check("t1_low_count", int'(low_count), 0);

    // 2: two qualifying items, including the last address
    mem[3] = 8'd0; mem[255] = 8'd5;
    run_scan(5, 0, -1, -1);
    check("t2_n_items", emit_log.size(), 2);
    check("t2_first_code", emit_log[0], 3);
    check("t2_second_code", emit_log[1], 255);
    check("t2_low_count", int'(low_count), 2);
    check("t2_latency", last_lat, 256 * 3 + 2 + 2);

    // 3: threshold max, random contents -> everything qualifies
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
    run_scan(255, 0, -1, -1);
    check("t3_low_count", int'(low_count), 256);
    check("t3_n_items", emit_log.size(), 256);
    check("t3_last_code", emit_log[255], 255);

    // threshold 0 -> only empty items
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i % 8);
    run_scan(0, 0, -1, -1);
    check("t0_low_count", int'(low_count), 32);

    // 4: backpressure on addr 7
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd10;
    mem[7] = 8'd2;
    run_scan(5, 20, -1, -1);
    check("t4_valid_cycles", valid_cycles, 21);
    check("t4_low_count", int'(low_count), 1);
    check("t4_code", emit_log[0], 7);

    // 5: start + threshold change mid-scan are ignored
    mem[7] = 8'd10; mem[20] = 8'd3; mem[150] = 8'd100;
    run_scan(5, 0, 100, -1);
    check("t5_low_count", int'(low_count), 1);
    check("t5_code", emit_log[0], 20);

    // 6: reset while addr 50 is being presented, then a fresh scan
    mem[20] = 8'd10; mem[150] = 8'd10; mem[10] = 8'd0; mem[50] = 8'd1;
    run_scan(5, 0, -1, 50);
    run_scan(5, 0, -1, -1);
    check("t6_low_count", int'(low_count), 2);
    check("t6_first_code", emit_log[0], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stock_scanner.md
Name: stock_scanner

Overview:
- Read-side counterpart to the inventory update core, which writes quantities into the 256-entry item memory.
- On a start pulse, sweeps every item code 0..DEPTH-1 through the memory read port.
- Compares each stored quantity against a low-stock threshold.
- Streams each qualifying (code, quantity) pair out on a valid/ready interface, then reports a total count.
- Sits beside the update core on the memory's read port and feeds the display/report logic.

Parameters:
- AW, 8, item-code/address width.
- DW, 8, quantity width.
- DEPTH, 256, number of entries scanned; DEPTH <= 2**AW.
- RD_LAT, 1, memory read latency in cycles from rd_en to rd_data valid; legal range 1..3.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a scan; ignored while busy.
- threshold  in  DW  low-stock limit; sampled only on an accepted start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  AW  memory read address.
- rd_data  in  DW  memory read data, valid RD_LAT cycles after rd_en.
- item_valid  out  1  qualifying item presented.
- item_ready  in  1  consumer accepts item when item_valid && item_ready.
- item_code  out  AW  address of qualifying item.
- item_quant  out  DW  stored quantity of qualifying item.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at scan end.
- low_count  out  AW+1  number of items emitted in the last scan; holds until next accepted start.

Behaviour:
- Reset (async, immediate) drives the following to zero: all outputs, address counter, threshold register, FSM state (IDLE).
- Reset mid-scan abandons the scan; no done pulse is generated.
- FSM states: IDLE, READ, WAIT, CHECK, EMIT, FINISH.
- IDLE: start=1 -> latch threshold, clear addr and low_count, busy=1 -> READ.
- READ: rd_en=1 for exactly one cycle, rd_addr=addr -> WAIT.
- WAIT: count RD_LAT cycles; rd_en=0, rd_addr held. Capture rd_data into quant_q on the cycle it is valid -> CHECK.
- CHECK, qualifying (quant_q <= threshold_q, unsigned): -> EMIT.
- CHECK, non-qualifying: if addr == DEPTH-1 -> FINISH, else addr+1 -> READ.
- EMIT: item_valid=1, item_code=addr, item_quant=quant_q.
- EMIT backpressure: while item_ready=0, hold item_valid, item_code and item_quant stable; never withdraw.
- EMIT handshake (item_valid && item_ready): low_count+1, item_valid=0 next cycle. Then FINISH if addr == DEPTH-1, else addr+1 -> READ.
- FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Throughput: non-qualifying item takes RD_LAT+2 cycles; qualifying item takes RD_LAT+3 cycles when item_ready is held high.
- Address wrap: addr never increments past DEPTH-1. Termination uses a compare, not counter overflow, so DEPTH=256 with AW=8 terminates correctly.
- low_count range 0..DEPTH. All-qualifying scan gives DEPTH (256 requires the AW+1 width).
- threshold=0: only empty items (quantity 0) qualify.
- threshold=2**DW-1: every item qualifies.
- start while busy: ignored, no effect on threshold_q or the scan.
- threshold changes during a scan: no effect.
- start on the same edge as done: ignored, because busy is still high in that cycle. A new scan needs start in IDLE.
- No writes issued. The block does not arbitrate with the update core. Memory contents changing mid-scan give per-read snapshot values.

Decomposition:
- Shared package inv_pkg:
  - AW/DW defaults.
  - Item-record typedef (code, quant) reused by the update core and display.
  - FSM state enum for stock_scanner.
- One natural sub-module: scan_rd_delay, a RD_LAT-deep valid shift register that asserts data-capture timing for WAIT. It keeps the latency handling out of the main FSM.

Test Plan:
1. Memory all 10, threshold=5, item_ready=1 -> zero items emitted, done after 256*(RD_LAT+2)+2 cycles, low_count=0.
2. Memory all 10 except addr 3=0 and addr 255=5, threshold=5 -> items (3,0) then (255,5) in order, low_count=2, rd_addr never exceeds 255.
3. threshold=255, memory random -> 256 items with codes 0..255 ascending, low_count=256, done pulse exactly one cycle.
4. addr 7 qualifies, item_ready low for 20 cycles -> item_valid stays high, item_code=7 and item_quant stable throughout, single transfer when ready rises, no duplicate.
5. Assert start and change threshold at addr 100 mid-scan -> both ignored, scan completes with the original threshold.
6. Assert rst at addr 50 with item_valid high -> all outputs 0 immediately, no done. Next start rescans from addr 0 with a fresh low_count.
